// File: rtl/shift_sequencer_pkg.sv
// Shared types and step sizes for the multi-cycle shift sequencer.
// The routing helper picks the next phase from a remaining shift amount.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BIG,
    SMALL,
    DONE
  } state_t;

  localparam int unsigned BIG_STEP   = 5;
  localparam int unsigned SMALL_STEP = 1;

  function automatic state_t route(input logic [31:0] amt);
    if (amt >= BIG_STEP) begin
      return BIG;
    end
    if (amt != '0) begin
      return SMALL;
    end
    return DONE;
  endfunction

endpackage

// File: rtl/shift_sequencer_sl5.sv
// Fixed shift-left-by-5 datapath slice; purely combinational.
// Bits pushed past the MSB are dropped.
module sl5 #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  output logic [N-1:0] o_y
);

  assign o_y = {i_a[N-6:0], 5'b00000};

endmodule

// File: rtl/shift_sequencer.sv
// Variable left shifter built from repeated 5-bit and 1-bit steps.
// Result is held in DONE until the consumer takes it.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int n  = 32,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [n-1:0]  in_num,
  input  logic [SW-1:0] in_shamt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [n-1:0]  out_num,
  output logic          busy,
  output logic [SW-1:0] steps
);

  localparam logic [SW-1:0] LP_BIG   = SW'(BIG_STEP);
  localparam logic [SW-1:0] LP_SMALL = SW'(SMALL_STEP);
  localparam logic [SW-1:0] LP_ONE   = SW'(1);

  state_t        r_state;
  logic [n-1:0]  r_acc;
  logic [SW-1:0] r_rem;
  logic [SW-1:0] r_steps;

  state_t        w_nstate;
  logic [n-1:0]  w_acc_d;
  logic [SW-1:0] w_rem_d;
  logic [SW-1:0] w_steps_d;
  logic [n-1:0]  w_sl5;
  logic [SW-1:0] w_rem_big;
  logic [SW-1:0] w_rem_small;

  sl5 #(
    .N(n)
  ) u_sl5 (
    .i_a(r_acc),
    .o_y(w_sl5)
  );

  assign w_rem_big   = r_rem - LP_BIG;
  assign w_rem_small = r_rem - LP_SMALL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_steps <= '0;
    end else begin
      r_state <= w_nstate;
      r_acc   <= w_acc_d;
      r_rem   <= w_rem_d;
      r_steps <= w_steps_d;
    end
  end

  always_comb begin
    w_nstate  = r_state;
    w_acc_d   = r_acc;
    w_rem_d   = r_rem;
    w_steps_d = r_steps;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_acc_d   = in_num;
          w_rem_d   = in_shamt;
          w_steps_d = '0;
          w_nstate  = route(32'(in_shamt));
        end
      end
      BIG: begin
        w_acc_d   = w_sl5;
        w_rem_d   = w_rem_big;
        w_steps_d = r_steps + LP_ONE;
        w_nstate  = route(32'(w_rem_big));
      end
      SMALL: begin
        w_acc_d   = {r_acc[n-2:0], 1'b0};
        w_rem_d   = w_rem_small;
        w_steps_d = r_steps + LP_ONE;
        w_nstate  = (w_rem_small == '0) ? DONE : SMALL;
      end
      DONE: begin
        if (out_ready) begin
          w_nstate = IDLE;
        end
      end
      default: begin
        w_nstate = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == BIG) || (r_state == SMALL);
  assign out_num   = out_valid ? r_acc : '0;
  assign steps     = r_steps;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed jobs plus random traffic
// compared every cycle against a latency/result reference model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_num;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_num;
  logic        busy;
  logic [4:0]  steps;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_phase = 0;
  int          m_cnt   = 0;
  int          m_steps = 0;
  logic [31:0] m_res   = '0;

  shift_sequencer #(
    .n (32),
    .SW(5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_num   (in_num),
    .in_shamt (in_shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_num  (out_num),
    .busy     (busy),
    .steps    (steps)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: idle(0) / working(1, m_cnt edges left) / done(2).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_cnt   = 0;
      m_steps = 0;
      m_res   = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_res   = in_num << in_shamt;
          m_steps = int'(in_shamt) / 5 + int'(in_shamt) % 5;
          m_cnt   = m_steps;
          m_phase = (m_cnt == 0) ? 2 : 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready", 32'(in_ready), 32'(m_phase == 0));
      check("out_valid", 32'(out_valid), 32'(m_phase == 2));
      check("busy", 32'(busy), 32'(m_phase == 1));
      if (m_phase == 2) begin
        check("out_num", out_num, m_res);
      end
      if (m_phase != 1) begin
        check("steps", 32'(steps), 32'(m_steps));
      end
    end
  end

  task automatic job(string tag, logic [31:0] num, logic [4:0] sh,
                     int exp_lat, logic [31:0] exp_out,
                     int hold, bit poke);
    int k;
    @(negedge clk);
    #1;
    in_valid  = 1'b1;
    in_num    = num;
    in_shamt  = sh;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_out"}, out_num, exp_out);
    check({tag, "_steps"}, 32'(steps), 32'(exp_lat));
    check({tag, "_model"}, m_res, exp_out);
    #1;
    in_valid = poke;
    in_num   = ~num;
    in_shamt = ~sh;
    repeat (hold) @(negedge clk);
    check({tag, "_hold_v"}, 32'(out_valid), 32'd1);
    check({tag, "_hold_d"}, out_num, exp_out);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_rel_rdy"}, 32'(in_ready), 32'd1);
    check({tag, "_rel_v"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_num    = '0;
    in_shamt  = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_num", out_num, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_steps", 32'(steps), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Reset two steps into a long job.
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_num   = 32'hFFFF_FFFF;
    in_shamt = 5'd31;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_out_num", out_num, 32'd0);
    check("mid_steps", 32'(steps), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    job("after_rst", 32'h0000_0001, 5'd1, 1, 32'h0000_0002, 0, 1'b0);
    job("zero", 32'h0000_BEEF, 5'd0, 0, 32'h0000_BEEF, 1, 1'b0);
    job("five", 32'h0000_0001, 5'd5, 1, 32'h0000_0020, 0, 1'b0);
    job("mixed", 32'h0000_0111, 5'd7, 3, 32'h0000_8880, 2, 1'b0);
    job("max", 32'h1357_9BDF, 5'd31, 7, 32'h8000_0000, 0, 1'b0);
    job("bp", 32'hF000_0000, 5'd4, 4, 32'h0000_0000, 5, 1'b1);
    job("mid9", 32'h0000_0003, 5'd9, 5, 32'h0000_0600, 1, 1'b1);

    repeat (3000) begin
      @(negedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_num    = $urandom;
      in_shamt  = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
